// File: rtl/topo_pkg.sv
// Shared definitions for the topology checker: FSM state encoding and fail codes.
package topo_pkg;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_RST  = 3'd1,
    ST_RUN  = 3'd2,
    ST_PASS = 3'd3,
    ST_FAIL = 3'd4
  } state_t;

  localparam logic [1:0] FC_NONE     = 2'd0;
  localparam logic [1:0] FC_MISMATCH = 2'd1;
  localparam logic [1:0] FC_TIMEOUT  = 2'd2;

endpackage

// File: rtl/chk_table.sv
// Expected-writeback table: one synchronous write port, one asynchronous read port.
module chk_table #(
  parameter int XLEN = 32,
  parameter int NCHK = 8,
  localparam int IW  = $clog2(NCHK)
) (
  input  logic            CLK,
  input  logic            we,
  input  logic [IW-1:0]   widx,
  input  logic [4:0]      wrd,
  input  logic [XLEN-1:0] wdata,
  input  logic [IW-1:0]   ridx,
  output logic [4:0]      rrd,
  output logic [XLEN-1:0] rdata
);

  logic [4:0]      rd_mem   [NCHK];
  logic [XLEN-1:0] data_mem [NCHK];

  // Contents are deliberately not reset; the table is loaded before each run.
  always_ff @(posedge CLK) begin
    if (we) begin
      rd_mem[widx]   <= wrd;
      data_mem[widx] <= wdata;
    end
  end

  assign rrd   = rd_mem[ridx];
  assign rdata = data_mem[ridx];

endmodule

// File: rtl/topo_checker.sv
// Drives reset to a DUT, then checks its register writebacks against an expected
// table in order, reporting PASS or FAIL (mismatch or timeout).
module topo_checker
  import topo_pkg::*;
#(
  parameter int XLEN       = 32,
  parameter int NCHK       = 8,
  parameter int RST_CYCLES = 2,
  parameter int TIMEOUT    = 40,
  localparam int IW        = $clog2(NCHK),
  localparam int PW        = IW + 1
) (
  input  logic            CLK,
  input  logic            rst,
  input  logic            start,
  input  logic            exp_we,
  input  logic [IW-1:0]   exp_idx,
  input  logic [4:0]      exp_rd,
  input  logic [XLEN-1:0] exp_data,
  input  logic [PW-1:0]   exp_cnt,
  input  logic            wb_en,
  input  logic [4:0]      wb_rd,
  input  logic [XLEN-1:0] wb_data,
  output logic            dut_rst,
  output logic            done,
  output logic            pass,
  output logic [1:0]      fail_code,
  output logic [IW-1:0]   err_idx,
  output logic [15:0]     cycles,
  output logic [2:0]      fsm_state
);

  localparam int RCW = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;

  state_t          state, state_n;
  logic [PW-1:0]   ptr, ptr_n, ptr_inc, cnt_lat, cnt_lat_n;
  logic [15:0]     cycles_n, cycles_inc;
  logic [1:0]      fc_n;
  logic [IW-1:0]   err_n;
  logic [RCW-1:0]  rcnt, rcnt_n;
  logic [4:0]      t_rd;
  logic [XLEN-1:0] t_data;
  logic            counted, match, timeout;

  chk_table #(.XLEN(XLEN), .NCHK(NCHK)) u_table (
    .CLK   (CLK),
    .we    (exp_we),
    .widx  (exp_idx),
    .wrd   (exp_rd),
    .wdata (exp_data),
    .ridx  (ptr[IW-1:0]),
    .rrd   (t_rd),
    .rdata (t_data)
  );

  assign counted    = wb_en && (wb_rd != 5'd0);
  assign match      = (wb_rd == t_rd) && (wb_data == t_data);
  assign ptr_inc    = ptr + PW'(1);
  assign cycles_inc = (cycles == 16'hFFFF) ? cycles : cycles + 16'd1;
  assign timeout    = cycles_inc >= 16'(TIMEOUT);

  always_ff @(posedge CLK) begin
    if (rst) begin
      state     <= ST_IDLE;
      ptr       <= '0;
      cnt_lat   <= '0;
      cycles    <= '0;
      fail_code <= FC_NONE;
      err_idx   <= '0;
      rcnt      <= '0;
    end else begin
      state     <= state_n;
      ptr       <= ptr_n;
      cnt_lat   <= cnt_lat_n;
      cycles    <= cycles_n;
      fail_code <= fc_n;
      err_idx   <= err_n;
      rcnt      <= rcnt_n;
    end
  end

  always_comb begin
    state_n   = state;
    ptr_n     = ptr;
    cnt_lat_n = cnt_lat;
    cycles_n  = cycles;
    fc_n      = fail_code;
    err_n     = err_idx;
    rcnt_n    = rcnt;
    // A new run from IDLE, PASS or FAIL clears all verdict state.
    if (start && (state == ST_IDLE || state == ST_PASS || state == ST_FAIL)) begin
      state_n   = ST_RST;
      ptr_n     = '0;
      cnt_lat_n = exp_cnt;
      cycles_n  = '0;
      fc_n      = FC_NONE;
      err_n     = '0;
      rcnt_n    = '0;
    end else begin
      case (state)
        ST_RST: begin
          if (rcnt == RCW'(RST_CYCLES - 1)) state_n = ST_RUN;
          else                              rcnt_n  = rcnt + RCW'(1);
        end
        ST_RUN: begin
          cycles_n = cycles_inc;
          if (ptr == cnt_lat) begin
            state_n = ST_PASS;
          end else if (counted && !match) begin
            state_n = ST_FAIL;
            fc_n    = FC_MISMATCH;
            err_n   = ptr[IW-1:0];
          end else if (counted && ptr_inc == cnt_lat) begin
            // Final match wins over a timeout landing on the same cycle.
            ptr_n   = ptr_inc;
            state_n = ST_PASS;
          end else begin
            if (counted) ptr_n = ptr_inc;
            if (timeout) begin
              state_n = ST_FAIL;
              fc_n    = FC_TIMEOUT;
            end
          end
        end
        default: ;
      endcase
    end
  end

  assign dut_rst   = (state == ST_IDLE) || (state == ST_RST);
  assign done      = (state == ST_PASS) || (state == ST_FAIL);
  assign pass      = (state == ST_PASS);
  assign fsm_state = state;

endmodule

// File: tb/tb_topo_checker.sv
// Directed bench for topo_checker: reset, PASS, mismatch, timeout, x0 filtering,
// timeout/match priority, rerun with a new table and mid-run reset.
module tb_topo_checker;

  localparam int XLEN = 32;
  localparam int NCHK = 8;
  localparam int IW   = 3;
  localparam int PW   = 4;

  logic            CLK = 1'b0;
  logic            rst, start, exp_we, wb_en;
  logic [IW-1:0]   exp_idx;
  logic [4:0]      exp_rd, wb_rd;
  logic [XLEN-1:0] exp_data, wb_data;
  logic [PW-1:0]   exp_cnt;
  logic            dut_rst, done, pass;
  logic [1:0]      fail_code;
  logic [IW-1:0]   err_idx;
  logic [15:0]     cycles;
  logic [2:0]      fsm_state;

  int n_checks = 0;
  int n_errors = 0;

  topo_checker #(.XLEN(XLEN), .NCHK(NCHK), .RST_CYCLES(2), .TIMEOUT(40)) dut (
    .CLK(CLK), .rst(rst), .start(start), .exp_we(exp_we), .exp_idx(exp_idx),
    .exp_rd(exp_rd), .exp_data(exp_data), .exp_cnt(exp_cnt), .wb_en(wb_en),
    .wb_rd(wb_rd), .wb_data(wb_data), .dut_rst(dut_rst), .done(done), .pass(pass),
    .fail_code(fail_code), .err_idx(err_idx), .cycles(cycles), .fsm_state(fsm_state)
  );

  always #5 CLK = ~CLK;

  // Inputs change and outputs are sampled 1 time unit after the rising edge.
  task automatic tick(input int n = 1);
    for (int i = 0; i < n; i++) begin
      @(posedge CLK);
      #1;
    end
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic load(input logic [IW-1:0] idx, input logic [4:0] rd, input logic [XLEN-1:0] data);
    exp_we = 1'b1; exp_idx = idx; exp_rd = rd; exp_data = data;
    tick();
    exp_we = 1'b0;
  endtask

  task automatic wb(input logic [4:0] rd, input logic [XLEN-1:0] data);
    wb_en = 1'b1; wb_rd = rd; wb_data = data;
    tick();
    wb_en = 1'b0;
  endtask

  // Pulses start, checks cleared counters, then measures the dut_rst window.
  task automatic start_run(input logic [PW-1:0] cnt);
    int n;
    exp_cnt = cnt; start = 1'b1;
    tick();
    start = 1'b0;
    check("start_done_clr", done, 0);
    check("start_cycles_clr", cycles, 0);
    check("start_fc_clr", fail_code, 0);
    check("start_err_clr", err_idx, 0);
    n = 0;
    while (dut_rst && n < 10) begin
      n++;
      tick();
    end
    check("rst_len", n, 2);
  endtask

  task automatic wait_done(input int budget);
    int n = 0;
    while (!done && n < budget) begin
      n++;
      tick();
    end
    check("done_in_budget", done, 1);
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; exp_we = 1'b0; exp_idx = '0; exp_rd = '0; exp_data = '0;
    exp_cnt = '0; wb_en = 1'b0; wb_rd = '0; wb_data = '0;
    tick(2);
    check("rst_state", fsm_state, 0);
    check("rst_dut_rst", dut_rst, 1);
    check("rst_done", done, 0);
    check("rst_pass", pass, 0);
    check("rst_fc", fail_code, 0);
    check("rst_err", err_idx, 0);
    check("rst_cycles", cycles, 0);
    rst = 1'b0;
    tick();

    // In-order matches on consecutive cycles.
    load(0, 5'd3, 32'd5); load(1, 5'd4, 32'd1); load(2, 5'd5, 32'd8);
    start_run(3);
    wb(5'd3, 32'd5); wb(5'd4, 32'd1); wb(5'd5, 32'd8);
    check("p1_done", done, 1);
    check("p1_pass", pass, 1);
    check("p1_fc", fail_code, 0);
    check("p1_cycles", cycles, 3);
    wb(5'd3, 32'd99);
    tick(2);
    check("p1_hold_pass", pass, 1);
    check("p1_hold_cycles", cycles, 3);
    check("p1_dut_rst", dut_rst, 0);

    // Wrong data on the second entry.
    start_run(3);
    wb(5'd3, 32'd5); wb(5'd4, 32'd0);
    check("mm_done", done, 1);
    check("mm_pass", pass, 0);
    check("mm_fc", fail_code, 1);
    check("mm_err", err_idx, 1);
    check("mm_cycles", cycles, 2);
    wb(5'd5, 32'd8);
    check("mm_hold_fc", fail_code, 1);

    // Too few writebacks: timeout at cycle 40.
    start_run(2);
    wb(5'd3, 32'd5);
    wait_done(60);
    check("to_pass", pass, 0);
    check("to_fc", fail_code, 2);
    check("to_cycles", cycles, 40);
    check("to_err", err_idx, 0);

    // x0 writes and wb_en=0 cycles do not advance; same-cycle table write is not seen.
    start_run(3);
    wb(5'd0, 32'd5); wb(5'd3, 32'd5); wb(5'd0, 32'd7);
    wb_rd = 5'd4; wb_data = 32'd1; tick();
    exp_we = 1'b1; exp_idx = 3'd1; exp_rd = 5'd4; exp_data = 32'd77;
    wb(5'd4, 32'd1);
    exp_we = 1'b0;
    wb(5'd0, 32'd1); wb(5'd5, 32'd8);
    check("x0_pass", pass, 1);
    check("x0_cycles", cycles, 7);
    load(1, 5'd4, 32'd1);

    // Final match landing exactly on the timeout cycle.
    start_run(1);
    tick(39);
    check("edge_not_done", done, 0);
    check("edge_cycles39", cycles, 39);
    wb(5'd3, 32'd5);
    check("edge_pass", pass, 1);
    check("edge_fc", fail_code, 0);
    check("edge_cycles", cycles, 40);

    // Rerun from PASS with a fresh table.
    load(0, 5'd7, 32'hDEAD); load(1, 5'd8, 32'hBEEF);
    start_run(2);
    wb(5'd7, 32'hDEAD); wb(5'd8, 32'hBEEF);
    check("new_pass", pass, 1);
    check("new_cycles", cycles, 2);

    // Empty table passes on the first RUN cycle.
    start_run(0);
    tick();
    check("zero_pass", pass, 1);
    check("zero_cycles", cycles, 1);

    // Reset in the middle of a run.
    start_run(2);
    wb(5'd7, 32'hDEAD);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    tick(3);
    check("abort_state", fsm_state, 0);
    check("abort_done", done, 0);
    check("abort_pass", pass, 0);
    check("abort_dut_rst", dut_rst, 1);
    check("abort_cycles", cycles, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
